// File: rtl/micro_waves_control_param.sv
// Microwave oven controller: keypad mm:ss entry, start/stop/door interlock,
// per-second countdown with prescaler, 7-segment digit outputs and
// magnetron duty-cycle power levels.
// Optional completion beeper: define MICRO_WAVES_BEEP_EN to enable it;
// otherwise beep is tied low and the beep timer is not built.
module micro_waves_control_param #(
    parameter int MIN_DIGITS    = 1,
    parameter int TICKS_PER_SEC = 1000,
    parameter int POWER_MAX     = 10,
    parameter int PWR_W         = 4
) (
    input  logic                    clk,
    input  logic                    clearn,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    door_closed,
    input  logic [9:0]              keyboard,
    input  logic [PWR_W-1:0]        power_level,
    output logic [6:0]              sec_ones_segs,
    output logic [6:0]              sec_tens_segs,
    output logic [7*MIN_DIGITS-1:0] min_segs,
    output logic                    mag_on,
    output logic                    beep
);
    localparam int PSC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int LVL_W = $clog2(POWER_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COOK  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
    logic [MIN_DIGITS-1:0][3:0]  min_q, min_d;
    logic [PSC_W-1:0]            presc_q, presc_d;
    logic [LVL_W-1:0]            elap_q, elap_d, lvl_q, lvl_d;
    logic                        mag_on_q, mag_on_d;
    logic                        startn_q, stopn_q;
    logic [9:0]                  key_q;

    logic                        start_edge, stop_edge, key_hit, time_zero, dec_zero, borrow;
    logic [3:0]                  key_val, dec_ones, dec_tens;
    logic [MIN_DIGITS-1:0][3:0]  dec_min;
    logic [LVL_W-1:0]            lvl_req;

    // Input edge detection, keypad decode, requested power level
    always_comb begin
        start_edge = startn_q & ~startn;
        stop_edge  = stopn_q & ~stopn;
        key_hit    = (key_q == '0) && $onehot(keyboard);
        key_val    = 4'd0;
        for (int k = 0; k < 10; k++)
            if (keyboard[k]) key_val = 4'(k);
        lvl_req = LVL_W'(POWER_MAX);
        if (power_level != '0 && 32'(power_level) <= POWER_MAX)
            lvl_req = LVL_W'(power_level);
        time_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) && (min_q == '0);
    end

    // One-second decrement of the held time, borrowing through the minutes
    always_comb begin
        dec_ones = sec_ones_q;
        dec_tens = sec_tens_q;
        dec_min  = min_q;
        borrow   = 1'b0;
        if (sec_ones_q != 4'd0) begin
            dec_ones = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_tens = sec_tens_q - 4'd1;
            dec_ones = 4'd9;
        end else begin
            dec_ones = 4'd9;
            dec_tens = 4'd5;
            borrow   = 1'b1;
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (borrow) begin
                    if (min_q[i] != 4'd0) begin
                        dec_min[i] = min_q[i] - 4'd1;
                        borrow     = 1'b0;
                    end else begin
                        dec_min[i] = 4'd9;
                    end
                end
            end
        end
        dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_min == '0);
    end

    // Controller state machine, time entry/countdown, prescaler and duty counter
    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_d      = min_q;
        presc_d    = presc_q;
        elap_d     = elap_q;
        lvl_d      = lvl_q;
        case (state_q)
            S_IDLE: begin
                if (key_hit) begin
                    for (int i = MIN_DIGITS - 1; i > 0; i--) min_d[i] = min_q[i-1];
                    min_d[0]   = sec_tens_q;
                    sec_tens_d = sec_ones_q;
                    sec_ones_d = key_val;
                end
                // Start uses the time held before any same-cycle key entry
                if (start_edge && !stop_edge && door_closed && !time_zero) begin
                    state_d = S_COOK;
                    presc_d = '0;
                    elap_d  = '0;
                    lvl_d   = lvl_req;
                end
            end
            S_COOK: begin
                // Pausing takes priority; the prescaler does not advance on that cycle
                if (stop_edge || !door_closed) begin
                    state_d = S_PAUSE;
                end else if (presc_q == PSC_W'(TICKS_PER_SEC - 1)) begin
                    presc_d    = '0;
                    sec_ones_d = dec_ones;
                    sec_tens_d = dec_tens;
                    min_d      = dec_min;
                    elap_d     = (elap_q == LVL_W'(POWER_MAX - 1)) ? '0 : elap_q + 1'b1;
                    if (dec_zero) state_d = S_DONE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_edge) begin
                    state_d    = S_IDLE;
                    sec_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    min_d      = '0;
                end else if (start_edge && door_closed) begin
                    state_d = S_COOK;
                end
            end
            default: begin
                if (start_edge || stop_edge || key_hit || !door_closed) state_d = S_IDLE;
            end
        endcase
        mag_on_d = (state_d == S_COOK) && (elap_d < lvl_d);
    end

    // State registers and input history
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q    <= S_IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_q      <= '0;
            presc_q    <= '0;
            elap_q     <= '0;
            lvl_q      <= '0;
            mag_on_q   <= 1'b0;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_q      <= min_d;
            presc_q    <= presc_d;
            elap_q     <= elap_d;
            lvl_q      <= lvl_d;
            mag_on_q   <= mag_on_d;
            startn_q   <= startn;
            stopn_q    <= stopn;
            key_q      <= keyboard;
        end
    end

`ifdef MICRO_WAVES_BEEP_EN
    localparam int BEEP_W = $clog2(3 * TICKS_PER_SEC + 1);
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    // Beep timer: loaded on DONE entry, counts down while in DONE, cleared on exit
    always_comb begin
        beep_cnt_d = '0;
        if (state_d == S_DONE) begin
            if (state_q != S_DONE)       beep_cnt_d = BEEP_W'(3 * TICKS_PER_SEC);
            else if (beep_cnt_q != '0)   beep_cnt_d = beep_cnt_q - 1'b1;
        end
    end

    // Beep timer register
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) beep_cnt_q <= '0;
        else         beep_cnt_q <= beep_cnt_d;
    end

    assign beep = (beep_cnt_q != '0);
`else
    assign beep = 1'b0;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign sec_ones_segs = seg7(sec_ones_q);
    assign sec_tens_segs = seg7(sec_tens_q);
    assign mag_on        = mag_on_q;

    for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min_seg
        assign min_segs[7*g +: 7] = seg7(min_q[g]);
    end
endmodule
